// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared helpers for the firebird7_in gate1 IJTAG TDR.
// Configuration macro: FIREBIRD7_IN_TDR_PARITY_EN (adds a parity bit to the chain).
package firebird7_in_gate1_tessent_tdr_pkg;

`ifdef FIREBIRD7_IN_TDR_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Chain position of the select bit, directly above the data field.
    function automatic int SEL_IDX(input int width);
        return width;
    endfunction

    // Chain position of the parity bit, directly above the select bit.
    function automatic int PAR_IDX(input int width);
        return width + 1;
    endfunction

    // Total scan chain length: data + select (+ parity).
    function automatic int tdr_len(input int width, input bit parity);
        return parity ? width + 2 : width + 1;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_parity_chk.sv
// Even-parity compare of the shifted data field against its parity bit.
// Used only when FIREBIRD7_IN_TDR_PARITY_EN is defined.
module firebird7_in_gate1_tessent_tdr_parity_chk #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par,
    output logic             mismatch
);

    // High when the XOR of the data bits disagrees with the carried parity bit.
    assign mismatch = (^data) != par;

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_obs.sv
// IJTAG TDR driving the IJTAG side of the gate1 data mux and observing its output.
// Chain layout: sr[WIDTH-1:0] data, sr[WIDTH] select, sr[WIDTH+1] parity (macro only).
// Configuration macro: FIREBIRD7_IN_TDR_PARITY_EN adds the parity bit and update_err.
// Per-cycle priority while ijtag_sel is high: reset > capture > shift > update.
module firebird7_in_gate1_tessent_tdr_obs
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] observe_in,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             ijtag_select_out
`ifdef FIREBIRD7_IN_TDR_PARITY_EN
    ,
    output logic             update_err
`endif
);

    localparam int L  = tdr_len(WIDTH, PARITY_EN);
    localparam int SI = SEL_IDX(WIDTH);

    logic [L-1:0]     sr;
    logic [L-1:0]     sr_cap;
    logic [WIDTH-1:0] upd_data;
    logic             upd_sel;
    logic             upd_ok;

    // Capture image: observed bus, current update select, and its parity when enabled.
    always_comb begin
        sr_cap            = '0;
        sr_cap[WIDTH-1:0] = observe_in;
        sr_cap[SI]        = upd_sel;
`ifdef FIREBIRD7_IN_TDR_PARITY_EN
        sr_cap[PAR_IDX(WIDTH)] = ^observe_in;
`endif
    end

`ifdef FIREBIRD7_IN_TDR_PARITY_EN
    logic par_bad;

    firebird7_in_gate1_tessent_tdr_parity_chk #(
        .WIDTH(WIDTH)
    ) u_parity_chk (
        .data    (sr[WIDTH-1:0]),
        .par     (sr[PAR_IDX(WIDTH)]),
        .mismatch(par_bad)
    );

    assign upd_ok = !par_bad;

    // Sticky error: set by a rejected update, cleared only by reset.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            update_err <= 1'b0;
        end else if (ijtag_sel && !ijtag_ce && !ijtag_se && ijtag_ue && par_bad) begin
            update_err <= 1'b1;
        end
    end
`else
    assign upd_ok = 1'b1;
`endif

    // Shift register: capture beats shift; data enters at the top, leaves at bit 0.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr <= '0;
        end else if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr <= sr_cap;
            end else if (ijtag_se) begin
                sr <= {ijtag_si, sr[L-1:1]};
            end
        end
    end

    // Update stage: loads only when neither capture nor shift claims the cycle.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            upd_data <= '0;
            upd_sel  <= 1'b0;
        end else if (ijtag_sel && !ijtag_ce && !ijtag_se && ijtag_ue && upd_ok) begin
            upd_data <= sr[WIDTH-1:0];
            upd_sel  <= sr[SI];
        end
    end

    assign ijtag_so         = sr[0];
    assign ijtag_data_out   = upd_data;
    assign ijtag_select_out = upd_sel;

endmodule
